// File: rtl/rrf_flag_ctrl.sv
// Retire-flag write controller: merges per-thread retire groups into one pending
// entry per thread, arbitrates a shared buffer write port, and serves bypassed reads.
module rrf_flag_ctrl #(
    parameter int unsigned DATA_WIDTH = 6,
    parameter int unsigned SLOTS      = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [SLOTS-1:0]            ret0_valid,
    input  logic [SLOTS*DATA_WIDTH-1:0] ret0_flags,
    input  logic [SLOTS-1:0]            ret1_valid,
    input  logic [SLOTS*DATA_WIDTH-1:0] ret1_flags,
    output logic [DATA_WIDTH-1:0]       buf_wdata,
    output logic [1:0]                  buf_wen,
    input  logic [DATA_WIDTH-1:0]       buf_rdata0,
    input  logic [DATA_WIDTH-1:0]       buf_rdata1,
    input  logic                        rd_clkEn,
    input  logic                        rd_thread,
    output logic [DATA_WIDTH:0]         rd_data,
    input  logic                        sync_req,
    output logic                        sync_ack
);

    logic [1:0]            w_new_v;
    logic [DATA_WIDTH-1:0] w_new_d [2];
    logic [DATA_WIDTH-1:0] w_buf_rd [2];
    logic                  w_gnt_v;
    logic                  w_gnt;

    logic [1:0]            r_pend_v;
    logic [DATA_WIDTH-1:0] r_pend_d [2];
    logic                  r_rr_ptr;
    logic [DATA_WIDTH:0]   r_rd_data;
    logic                  r_sync_ack;

    // Youngest valid slot wins: later loop iterations overwrite earlier ones.
    always_comb begin
        w_new_v    = {|ret1_valid, |ret0_valid};
        w_new_d[0] = '0;
        w_new_d[1] = '0;
        for (int unsigned i = 0; i < SLOTS; i++) begin
            if (ret0_valid[i]) w_new_d[0] = ret0_flags[i*DATA_WIDTH +: DATA_WIDTH];
            if (ret1_valid[i]) w_new_d[1] = ret1_flags[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign w_buf_rd[0] = buf_rdata0;
    assign w_buf_rd[1] = buf_rdata1;

    // Round-robin only matters when both threads are pending.
    always_comb begin
        w_gnt_v = |r_pend_v;
        w_gnt   = (&r_pend_v) ? r_rr_ptr : r_pend_v[1];
    end

    always_comb begin
        buf_wen   = 2'b00;
        buf_wdata = '0;
        if (w_gnt_v) begin
            buf_wen   = w_gnt ? 2'b10 : 2'b01;
            buf_wdata = r_pend_d[w_gnt];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_v    <= '0;
            r_pend_d[0] <= '0;
            r_pend_d[1] <= '0;
            r_rr_ptr    <= 1'b0;
            r_rd_data   <= '0;
            r_sync_ack  <= 1'b0;
        end else begin
            for (int unsigned t = 0; t < 2; t++) begin
                if (w_new_v[t]) begin
                    r_pend_v[t] <= 1'b1;
                    r_pend_d[t] <= w_new_d[t];
                end else if (w_gnt_v && (w_gnt == 1'(t))) begin
                    r_pend_v[t] <= 1'b0;
                end
            end
            if (w_gnt_v) r_rr_ptr <= ~w_gnt;

            if (rd_clkEn) begin
                if (w_new_v[rd_thread])
                    r_rd_data <= {1'b1, w_new_d[rd_thread]};
                else if (r_pend_v[rd_thread])
                    r_rd_data <= {1'b1, r_pend_d[rd_thread]};
                else
                    r_rd_data <= {1'b0, w_buf_rd[rd_thread]};
            end

            r_sync_ack <= sync_req && (r_pend_v == 2'b00) && (w_new_v == 2'b00);
        end
    end

    assign rd_data  = r_rd_data;
    assign sync_ack = r_sync_ack;

endmodule
